// File: rtl/block_interleaver_pkg.sv
// interleaver_pkg: constants and types shared by the transmit-side block
// interleaver and the receive-side de-interleaver.
//   WORD_W                    stream word width
//   DEF_CODEWORD_SIZE_IN_32   default words per codeword (C)
//   DEF_NUM_CODEWORDS         default codewords per block (N)
//   BLOCK_SIZE                default words per block (C*N)
//   *_CNT_W                   default counter widths
//   bank_sel_t / bank_flip    ping-pong bank selector and its toggle
//   cnt_w                     width needed to count 0..n-1 (at least 1)
package interleaver_pkg;

    localparam int unsigned WORD_W                  = 32;
    localparam int unsigned DEF_CODEWORD_SIZE_IN_32 = 65;
    localparam int unsigned DEF_NUM_CODEWORDS       = 4;
    localparam int unsigned BLOCK_SIZE              = DEF_CODEWORD_SIZE_IN_32 * DEF_NUM_CODEWORDS;

    localparam int unsigned BLK_CNT_W  = $clog2(BLOCK_SIZE);
    localparam int unsigned CW_CNT_W   = $clog2(DEF_NUM_CODEWORDS);
    localparam int unsigned WORD_CNT_W = $clog2(DEF_CODEWORD_SIZE_IN_32);

    typedef enum logic {
        BANK_0 = 1'b0,
        BANK_1 = 1'b1
    } bank_sel_t;

    function automatic int unsigned cnt_w(input int unsigned n);
        return (n <= 32'd2) ? 32'd1 : $clog2(n);
    endfunction

    function automatic bank_sel_t bank_flip(input bank_sel_t b);
        return (b == BANK_0) ? BANK_1 : BANK_0;
    endfunction

endpackage

// File: rtl/block_interleaver_if.sv
// block_interleaver_if: one 32-bit AXI-Stream link.
//   tdata/tvalid/tlast  driven by the master
//   tready              driven by the slave
interface block_interleaver_if;
    import interleaver_pkg::*;

    logic [WORD_W-1:0] tdata;
    logic              tvalid;
    logic              tready;
    logic              tlast;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/block_interleaver_axis_skid_out.sv
// axis_skid_out: 2-entry registered AXI-Stream output buffer.
//   push_*      word entering the buffer (caller guarantees count < 2)
//   out_*       registered stream output, held stable until out_ready
//   count       words currently held (0..2), used by the caller as credit
module axis_skid_out
    import interleaver_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              push_valid,
    input  logic [WORD_W-1:0] push_data,
    input  logic              push_last,
    input  logic              out_ready,
    output logic [WORD_W-1:0] out_data,
    output logic              out_valid,
    output logic              out_last,
    output logic [1:0]        count
);
    logic              head_valid_q, head_valid_d;
    logic [WORD_W-1:0] head_data_q, head_data_d;
    logic              head_last_q, head_last_d;
    logic              spare_valid_q, spare_valid_d;
    logic [WORD_W-1:0] spare_data_q, spare_data_d;
    logic              spare_last_q, spare_last_d;
    logic              head_free_s;

    // Next state: head refills from the spare slot first, then from the push.
    always_comb begin
        head_valid_d  = head_valid_q;
        head_data_d   = head_data_q;
        head_last_d   = head_last_q;
        spare_valid_d = spare_valid_q;
        spare_data_d  = spare_data_q;
        spare_last_d  = spare_last_q;
        head_free_s   = !head_valid_q || out_ready;
        if (head_free_s) begin
            if (spare_valid_q) begin
                head_valid_d  = 1'b1;
                head_data_d   = spare_data_q;
                head_last_d   = spare_last_q;
                spare_valid_d = push_valid;
                if (push_valid) begin
                    spare_data_d = push_data;
                    spare_last_d = push_last;
                end else begin
                    spare_data_d = spare_data_q;
                    spare_last_d = spare_last_q;
                end
            end else if (push_valid) begin
                head_valid_d = 1'b1;
                head_data_d  = push_data;
                head_last_d  = push_last;
            end else begin
                head_valid_d = 1'b0;
            end
        end else begin
            if (push_valid) begin
                spare_valid_d = 1'b1;
                spare_data_d  = push_data;
                spare_last_d  = push_last;
            end else begin
                spare_valid_d = spare_valid_q;
            end
        end
    end

    // Buffer registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_valid_q  <= 1'b0;
            head_data_q   <= '0;
            head_last_q   <= 1'b0;
            spare_valid_q <= 1'b0;
            spare_data_q  <= '0;
            spare_last_q  <= 1'b0;
        end else begin
            head_valid_q  <= head_valid_d;
            head_data_q   <= head_data_d;
            head_last_q   <= head_last_d;
            spare_valid_q <= spare_valid_d;
            spare_data_q  <= spare_data_d;
            spare_last_q  <= spare_last_d;
        end
    end

    assign out_valid = head_valid_q;
    assign out_data  = head_data_q;
    assign out_last  = head_last_q;
    assign count     = {1'b0, head_valid_q} + {1'b0, spare_valid_q};
endmodule

// File: rtl/block_interleaver.sv
// block_interleaver: ping-pong block interleaver. Input is N codewords of C
// words written linearly; output is word 0 of every codeword, then word 1, ...
//   clk, rst    clock, asynchronous active-high reset
//   s_axis      input stream (slave), tlast expected on word B-1 of a block
//   m_axis      output stream (master), registered, tlast on last word
//   frame_err   one-cycle pulse after a word whose tlast disagrees with position
module block_interleaver
    import interleaver_pkg::*;
#(
    parameter int unsigned CODEWORD_SIZE_IN_32 = DEF_CODEWORD_SIZE_IN_32,
    parameter int unsigned NUM_CODEWORDS       = DEF_NUM_CODEWORDS
) (
    input  logic                 clk,
    input  logic                 rst,
    block_interleaver_if.slave   s_axis,
    block_interleaver_if.master  m_axis,
    output logic                 frame_err
);
    localparam int unsigned C      = CODEWORD_SIZE_IN_32;
    localparam int unsigned N      = NUM_CODEWORDS;
    localparam int unsigned B      = C * N;
    localparam int unsigned WC_W   = cnt_w(B);
    localparam int unsigned CW_W   = cnt_w(N);
    localparam int unsigned WD_W   = cnt_w(C);
    localparam int unsigned ADDR_W = cnt_w(2 * B);

    localparam logic [WC_W-1:0]   WC_LAST  = WC_W'(B - 1);
    localparam logic [WC_W-1:0]   WC_STEP  = WC_W'(C);
    localparam logic [CW_W-1:0]   CW_LAST  = CW_W'(N - 1);
    localparam logic [WD_W-1:0]   WD_LAST  = WD_W'(C - 1);
    localparam logic [ADDR_W-1:0] BANK_OFS = ADDR_W'(B);

    logic [WORD_W-1:0] mem [0:2*B-1];

    logic [WC_W-1:0] wr_count_q, wr_count_d;
    bank_sel_t       wr_bank_q, wr_bank_d;
    bank_sel_t       rd_bank_q, rd_bank_d;
    logic [1:0]      full_q, full_d;
    logic            frame_err_q, frame_err_d;
    logic [CW_W-1:0] rd_cw_q, rd_cw_d;
    logic [WD_W-1:0] rd_word_q, rd_word_d;
    logic [WC_W-1:0] rd_base_q, rd_base_d;

    logic              wr_acc_s, wr_at_end_s, rd_issue_s, rd_at_end_s;
    logic [ADDR_W-1:0] wr_addr_s, rd_addr_s;
    logic [1:0]        skid_count_s, credit_s;

    assign s_axis.tready = !full_q[wr_bank_q];
    assign wr_acc_s      = s_axis.tvalid && s_axis.tready;
    assign wr_at_end_s   = (wr_count_q == WC_LAST);
    assign credit_s      = 2'd2 - skid_count_s;
    assign rd_issue_s    = full_q[rd_bank_q] && (credit_s != 2'd0);
    assign rd_at_end_s   = (rd_cw_q == CW_LAST) && (rd_word_q == WD_LAST);

    // Bank bit selects the upper half of the shared RAM.
    assign wr_addr_s = (wr_bank_q == BANK_1) ? BANK_OFS + ADDR_W'(wr_count_q) : ADDR_W'(wr_count_q);
    assign rd_addr_s = (rd_bank_q == BANK_1) ? BANK_OFS + ADDR_W'(rd_base_q) : ADDR_W'(rd_base_q);

    // Write counter, bank toggle and framing check.
    always_comb begin
        wr_count_d  = wr_count_q;
        wr_bank_d   = wr_bank_q;
        frame_err_d = 1'b0;
        if (wr_acc_s) begin
            frame_err_d = (s_axis.tlast != wr_at_end_s);
            if (wr_at_end_s) begin
                wr_count_d = '0;
                wr_bank_d  = bank_flip(wr_bank_q);
            end else begin
                wr_count_d = wr_count_q + WC_W'(1);
            end
        end else begin
            wr_count_d = wr_count_q;
        end
    end

    // Column-major read walk; base steps by C, and on codeword wrap restarts at the next word.
    always_comb begin
        rd_cw_d   = rd_cw_q;
        rd_word_d = rd_word_q;
        rd_base_d = rd_base_q;
        rd_bank_d = rd_bank_q;
        if (rd_issue_s) begin
            if (rd_cw_q == CW_LAST) begin
                rd_cw_d = '0;
                if (rd_word_q == WD_LAST) begin
                    rd_word_d = '0;
                    rd_base_d = '0;
                    rd_bank_d = bank_flip(rd_bank_q);
                end else begin
                    rd_word_d = rd_word_q + WD_W'(1);
                    rd_base_d = WC_W'(rd_word_q) + WC_W'(1);
                end
            end else begin
                rd_cw_d   = rd_cw_q + CW_W'(1);
                rd_base_d = rd_base_q + WC_STEP;
            end
        end else begin
            rd_cw_d = rd_cw_q;
        end
    end

    // Full flags: a filling bank and a draining bank are always different, so both may update.
    always_comb begin
        full_d = full_q;
        if (wr_acc_s && wr_at_end_s) begin
            full_d[wr_bank_q] = 1'b1;
        end else begin
            full_d = full_d;
        end
        if (rd_issue_s && rd_at_end_s) begin
            full_d[rd_bank_q] = 1'b0;
        end else begin
            full_d = full_d;
        end
    end

    // Control registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_count_q  <= '0;
            wr_bank_q   <= BANK_0;
            rd_bank_q   <= BANK_0;
            full_q      <= 2'b00;
            frame_err_q <= 1'b0;
            rd_cw_q     <= '0;
            rd_word_q   <= '0;
            rd_base_q   <= '0;
        end else begin
            wr_count_q  <= wr_count_d;
            wr_bank_q   <= wr_bank_d;
            rd_bank_q   <= rd_bank_d;
            full_q      <= full_d;
            frame_err_q <= frame_err_d;
            rd_cw_q     <= rd_cw_d;
            rd_word_q   <= rd_word_d;
            rd_base_q   <= rd_base_d;
        end
    end

    // RAM write port; the read and write banks never coincide, so no bypass is needed.
    always_ff @(posedge clk) begin
        if (wr_acc_s) begin
            mem[wr_addr_s] <= s_axis.tdata;
        end
    end

    // The RAM read register is the buffer slot itself, so an issued read is held one cycle later.
    axis_skid_out u_skid (
        .clk        (clk),
        .rst        (rst),
        .push_valid (rd_issue_s),
        .push_data  (mem[rd_addr_s]),
        .push_last  (rd_at_end_s),
        .out_ready  (m_axis.tready),
        .out_data   (m_axis.tdata),
        .out_valid  (m_axis.tvalid),
        .out_last   (m_axis.tlast),
        .count      (skid_count_s)
    );

    assign frame_err = frame_err_q;
endmodule

// File: tb/tb_block_interleaver.sv
module tb_block_interleaver;
    localparam int C_S = 3;
    localparam int N_S = 2;
    localparam int B_S = 6;

    typedef struct {
        logic [31:0] din;
        logic        lin;
        logic [31:0] dexp;
        logic        lexp;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic fe_s, fe_d;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    block_interleaver_if s_in();
    block_interleaver_if s_out();
    block_interleaver_if d_in();
    block_interleaver_if d_out();

    block_interleaver #(.CODEWORD_SIZE_IN_32(C_S), .NUM_CODEWORDS(N_S)) dut_s (
        .clk(clk), .rst(rst), .s_axis(s_in.slave), .m_axis(s_out.master), .frame_err(fe_s));
    block_interleaver dut_d (
        .clk(clk), .rst(rst), .s_axis(d_in.slave), .m_axis(d_out.master), .frame_err(fe_d));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // scoreboard state for the small instance
    logic [31:0] blk_s[$];
    logic [32:0] exp_s[$];
    logic [32:0] got_s[$];
    vec_t        tab[$];
    int          last_hs_cyc = 0, rise_cyc = 0, fe_cnt = 0, fe_cyc = 0, out_cnt = 0;
    logic        prev_v = 1'b0, prev_r = 1'b0, prev_l = 1'b0, exp_fe = 1'b0;
    logic [31:0] prev_d = 32'd0;
    logic [32:0] e;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, expv);
        end
    endtask

    // Reference model: collect B_S accepted words, emit them in column-major order.
    always @(negedge clk) begin
        if (rst) begin
            blk_s.delete();
            exp_s.delete();
            prev_v = 1'b0;
            exp_fe = 1'b0;
        end else begin
            check("frame_err", fe_s, exp_fe);
            exp_fe = 1'b0;
            if (prev_v && !prev_r) begin
                check("hold_valid", s_out.tvalid, 1);
                check("hold_data", s_out.tdata, prev_d);
                check("hold_last", s_out.tlast, prev_l);
            end
            if (s_out.tvalid && !prev_v) rise_cyc = cyc;
            if (fe_s) begin
                fe_cnt++;
                fe_cyc = cyc;
            end
            if (s_in.tvalid && s_in.tready) begin
                exp_fe = (s_in.tlast != (blk_s.size() == B_S - 1));
                blk_s.push_back(s_in.tdata);
                last_hs_cyc = cyc;
                if (blk_s.size() == B_S) begin
                    for (int k = 0; k < B_S; k++)
                        exp_s.push_back({(k == B_S - 1), blk_s[(k % N_S) * C_S + k / N_S]});
                    blk_s.delete();
                end
            end
            if (s_out.tvalid && s_out.tready) begin
                got_s.push_back({s_out.tlast, s_out.tdata});
                out_cnt++;
                check("sb_expected_pending", (exp_s.size() != 0), 1);
                if (exp_s.size() != 0) begin
                    e = exp_s.pop_front();
                    check("sb_data", s_out.tdata, e[31:0]);
                    check("sb_last", s_out.tlast, e[32]);
                end
            end
            prev_v = s_out.tvalid;
            prev_r = s_out.tready;
            prev_d = s_out.tdata;
            prev_l = s_out.tlast;
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Called at posedge+1; returns at posedge+1 after the word is accepted.
    task automatic send_s(input logic [31:0] d, input logic l);
        int n;
        n = 0;
        s_in.tdata  = d;
        s_in.tlast  = l;
        s_in.tvalid = 1'b1;
        @(negedge clk);
        while (!s_in.tready && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (n >= 200) check("send_ready_timeout", s_in.tready, 1);
        @(posedge clk);
        #1;
        s_in.tvalid = 1'b0;
        s_in.tlast  = 1'b0;
    endtask

    task automatic wait_got(input int n, input int budget);
        int k;
        k = 0;
        while (got_s.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        check("out_count", got_s.size(), n);
        @(posedge clk);
        #1;
    endtask

    task automatic send_tab();
        foreach (tab[k]) send_s(tab[k].din, tab[k].lin);
    endtask

    task automatic compare_tab(input string tag);
        foreach (tab[k]) begin
            if (k < got_s.size()) begin
                check({tag, "_data"}, got_s[k][31:0], tab[k].dexp);
                check({tag, "_last"}, got_s[k][32], tab[k].lexp);
            end
        end
    endtask

    int   ord_a[6]  = '{0, 3, 1, 4, 2, 5};
    int   ord_b[12] = '{0, 3, 1, 4, 2, 5, 6, 9, 7, 10, 8, 11};
    int   t2, fe0, oc0, w, blk, kk;
    logic done_e;

    initial begin
        s_in.tvalid = 1'b0; s_in.tdata = 32'd0; s_in.tlast = 1'b0; s_out.tready = 1'b1;
        d_in.tvalid = 1'b0; d_in.tdata = 32'd0; d_in.tlast = 1'b0; d_out.tready = 1'b1;

        // reset state
        @(negedge clk);
        check("rst_s_tvalid", s_out.tvalid, 0);
        check("rst_s_tlast", s_out.tlast, 0);
        check("rst_s_tdata", s_out.tdata, 0);
        check("rst_s_frame_err", fe_s, 0);
        check("rst_d_tvalid", d_out.tvalid, 0);
        check("rst_d_tdata", d_out.tdata, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_s_tready", s_in.tready, 1);
        check("rst_d_tready", d_in.tready, 1);
        @(posedge clk);
        #1;

        // basic order, tlast and latency
        do_reset();
        tab.delete();
        for (int k = 0; k < 6; k++)
            tab.push_back('{din: 32'(k), lin: (k == 5), dexp: 32'(ord_a[k]), lexp: (k == 5)});
        got_s.delete();
        send_tab();
        wait_got(6, 50);
        compare_tab("basic");
        check("first_valid_latency", 32'(rise_cyc - last_hs_cyc), 2);

        // output stalled: both banks fill, head word held
        do_reset();
        tab.delete();
        for (int k = 0; k < 12; k++)
            tab.push_back('{din: 32'(k), lin: (k % 6 == 5), dexp: 32'(ord_b[k]), lexp: (k % 6 == 5)});
        got_s.delete();
        s_out.tready = 1'b0;
        send_tab();
        @(negedge clk);
        check("stall_s_tready", s_in.tready, 0);
        for (int k = 0; k < 5; k++) begin
            check("stall_tvalid", s_out.tvalid, 1);
            check("stall_tdata", s_out.tdata, 0);
            @(negedge clk);
        end
        @(posedge clk);
        #1 s_out.tready = 1'b1;
        wait_got(12, 100);
        compare_tab("stall");

        // misplaced tlast on word 2 (and the regular one on word 5)
        do_reset();
        got_s.delete();
        fe0 = fe_cnt;
        t2 = 0;
        for (int k = 0; k < 6; k++) begin
            send_s(32'(20 + k), (k == 2) || (k == 5));
            if (k == 2) t2 = last_hs_cyc;
        end
        wait_got(6, 50);
        check("fe_pulse_count", 32'(fe_cnt - fe0), 1);
        check("fe_pulse_cycle", 32'(fe_cyc), 32'(t2 + 1));
        for (int k = 0; k < 6; k++)
            if (k < got_s.size())
                check("fe_order", got_s[k][31:0], 32'(20 + (k % 2) * 3 + k / 2));

        // reset mid-block with a word held at the output
        do_reset();
        s_out.tready = 1'b0;
        for (int k = 0; k < 6; k++) send_s(32'(30 + k), (k == 5));
        for (int k = 0; k < 4; k++) send_s(32'(40 + k), (k == 3));
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_tvalid", s_out.tvalid, 0);
        check("mid_rst_tlast", s_out.tlast, 0);
        check("mid_rst_tdata", s_out.tdata, 0);
        check("mid_rst_frame_err", fe_s, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("mid_rst_tready", s_in.tready, 1);
        @(posedge clk);
        #1 s_out.tready = 1'b1;
        tab.delete();
        for (int k = 0; k < 6; k++)
            tab.push_back('{din: 32'(100 + k), lin: (k == 5), dexp: 32'(100 + ord_a[k]), lexp: (k == 5)});
        got_s.delete();
        send_tab();
        wait_got(6, 50);
        compare_tab("post_rst");

        // random valid/ready over 10 blocks against the scoreboard
        do_reset();
        oc0 = out_cnt;
        done_e = 1'b0;
        fork
            begin
                for (int i = 0; i < 60; i++) begin
                    repeat ($urandom_range(0, 2)) begin
                        @(posedge clk);
                        #1;
                    end
                    send_s($urandom, (i % 6 == 5));
                end
                done_e = 1'b1;
            end
            begin
                while (!done_e) begin
                    s_out.tready = 1'($urandom_range(0, 1));
                    @(posedge clk);
                    #1;
                end
            end
        join
        s_out.tready = 1'b1;
        w = 0;
        while (exp_s.size() != 0 && w < 100) begin
            @(negedge clk);
            w++;
        end
        check("rand_drained", exp_s.size(), 0);
        check("rand_out_count", 32'(out_cnt - oc0), 60);
        @(posedge clk);
        #1;

        // default size: three blocks streamed back to back
        fork
            begin
                for (int i = 0; i < 780; i++) begin
                    d_in.tdata  = 32'(i);
                    d_in.tlast  = (i % 260 == 259);
                    d_in.tvalid = 1'b1;
                    @(negedge clk);
                    check("d_s_tready", d_in.tready, 1);
                    check("d_frame_err", fe_d, 0);
                    @(posedge clk);
                    #1;
                end
                d_in.tvalid = 1'b0;
                d_in.tlast  = 1'b0;
            end
            begin
                w = 0;
                @(negedge clk);
                while (!d_out.tvalid && w < 600) begin
                    w++;
                    @(negedge clk);
                end
                for (int j = 0; j < 780; j++) begin
                    blk = j / 260;
                    kk  = j % 260;
                    check("d_tvalid", d_out.tvalid, 1);
                    check("d_tdata", d_out.tdata, 32'(blk * 260 + (kk % 4) * 65 + kk / 4));
                    check("d_tlast", d_out.tlast, (kk == 259));
                    @(negedge clk);
                end
            end
        join

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/block_interleaver.md
# block_interleaver

Transmit-side block interleaver for the 32-bit AXI-Stream codeword path, the exact inverse of the receive-side de-interleaver. It accepts NUM_CODEWORDS codewords of CODEWORD_SIZE_IN_32 words each, sent codeword-after-codeword. It emits them word-interleaved: word 0 of every codeword, then word 1 of every codeword, and so on. Two ping-pong banks let one block be written while the previous block is read out, and the output is fully registered.

## Interface
- CODEWORD_SIZE_IN_32, 65, words per codeword (C), ≥2
- NUM_CODEWORDS, 4, codewords per block (N), ≥2
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- s_axis_tdata  in  32  input word
- s_axis_tvalid  in  1  input valid
- s_axis_tready  out  1  input ready
- s_axis_tlast  in  1  marks the last word of an input block
- m_axis_tdata  out  32  output word, registered
- m_axis_tvalid  out  1  output valid, registered
- m_axis_tready  in  1  output ready
- m_axis_tlast  out  1  marks the last word of an output block
- frame_err  out  1  one-cycle pulse when s_axis_tlast disagrees with the block position

## Operation
- B = C*N. Two banks of B words each; address = cw*C + word.
- Write side:
  - wr_count runs 0..B-1 and addresses the bank linearly.
  - s_axis_tready = !full[wr_bank].
  - On the accepted word with wr_count == B-1: set full[wr_bank], toggle wr_bank, clear wr_count.
- tlast check:
  - frame_err pulses the cycle after an accepted word where s_axis_tlast != (wr_count == B-1).
  - The word is still stored. The counters are not resynchronised.
- Read side:
  - Counters rd_cw (0..N-1) and rd_word (0..C-1).
  - The address is held in a base register: +C per read; on rd_cw wrap, reset to rd_word+1. No divide or modulo hardware.
  - Read order: for rd_word 0..C-1, for rd_cw 0..N-1.
  - A read is issued when full[rd_bank] && credit > 0.
  - credit = 2 − (in-flight reads + words held in the output buffer).
  - The read that issues the word at index B-1 clears full[rd_bank] in that same cycle and toggles rd_bank. The bank is reusable once the word has been fetched.
- Memory is synchronous-read: data is valid one cycle after issue and goes into a 2-entry output buffer.
- m_axis_tlast travels with the word at read index B-1.
- If a write sets full[X] and a read clears full[Y] in the same cycle, both take effect. X == Y cannot occur.
- Reset (including mid-block):
  - full flags, wr_bank, rd_bank, all counters, credit and buffer are cleared.
  - Outputs go to 0: m_axis_tvalid, m_axis_tlast, m_axis_tdata, frame_err. s_axis_tready goes to 1 after reset.
  - Partial blocks are discarded.

## Timing
- Cycle T: the last input word of a block is accepted.
- T+1: full is set and the first read is issued.
- T+2: m_axis_tvalid = 1 with the first output word.
- With m_axis_tready held high, throughput is 1 word/cycle sustained, back-to-back across blocks with no bubble.
- Output is AXIS-compliant: tdata and tlast are stable while tvalid && !tready. tvalid never drops without a handshake.
- Input stalls only when both banks are full. Bank-freeing takes effect one cycle after the final read issue; s_axis_tready rises then.
- The output buffer never overflows: the credit gate guarantees at most 2 words are outstanding.

## Structure
- Shared package interleaver_pkg:
  - BLOCK_SIZE
  - Counter width constants derived via $clog2
  - Bank-select type
  - Shared with the de-interleaver.
- Sub-module axis_skid_out: a 2-entry registered output buffer with a credit/count output. It can be reused by the de-interleaver rework.
- Memory: two inferred simple-dual-port RAMs, or one RAM of 2B words with the bank bit as the address MSB.

## Test plan
- C=3, N=2, input 0..5 with tlast on word 5 and tready=1 → output 0,3,1,4,2,5; tlast on word 5; first tvalid 2 cycles after the last input handshake.
- Default parameters (C=65, N=4): stream 3 blocks continuously (input i = i) → each block's output is blk*260 + (k%4)*65 + k/4 for k = 0..259; no output bubbles; s_axis_tready never drops.
- Hold m_axis_tready=0 with C=3, N=2 → after 12 words s_axis_tready=0, m_axis_tdata stays stable at 0; release tready → 0,3,1,4,2,5,6,9,7,10,8,11.
- Random tvalid/tready toggling over 10 blocks → output matches the reference model exactly; no lost or duplicated words.
- tlast asserted on word 2 of 6 → frame_err pulses once, one cycle later; data order is unaffected.
- Assert rst mid-block after 4 words → all outputs 0 during reset; the next full block 100..105 emerges as 100,103,101,104,102,105.
